// File: rtl/reg_read_unit.sv
// ---------------------------------------------------------------------------
// reg_read_unit
//
// Register-file read stage. Reads two source operands from the flattened
// r0..r14 register outputs (r15 is the PC plus a fixed offset), forwards a
// same-cycle writeback, and presents the result as registered rd1/rd2
// behind a valid/ack handshake with one request per cycle of throughput.
//
// Optional feature (macro REG_READ_SCOREBOARD_EN):
//   When defined, a 15-entry busy-bit scoreboard tracks destinations that
//   were reserved by issueEn and not yet written back. A request whose
//   source is busy stalls until the matching writeback arrives, in which
//   case the writeback value is forwarded. When undefined, issueEn and
//   issueReg are ignored and the unit never stalls.
//
// Parameters:
//   DATA_W      register data width
//   PC_OFFSET   value added to pcIn when r15 is read (sum wraps to DATA_W)
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   regFlat      r0..r14, r0 in the low DATA_W bits
//   pcIn         current PC
//   writeDataEn  writeback strobe
//   regToWrite   writeback register index
//   writeData    writeback value
//   rdReq        read request valid
//   ra1, ra2     source register indices
//   rdReady      request accepted this cycle when high together with rdReq
//   rd1, rd2     registered read data
//   outValid     rd1/rd2 hold unconsumed data
//   outAck       consumer takes rd1/rd2
//   issueEn      destination-reserve strobe (scoreboard build only)
//   issueReg     register index to reserve (scoreboard build only)
// ---------------------------------------------------------------------------
module reg_read_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_OFFSET = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15*DATA_W-1:0]   regFlat,
  input  logic [DATA_W-1:0]      pcIn,
  input  logic                   writeDataEn,
  input  logic [3:0]             regToWrite,
  input  logic [DATA_W-1:0]      writeData,
  input  logic                   rdReq,
  input  logic [3:0]             ra1,
  input  logic [3:0]             ra2,
  output logic                   rdReady,
  output logic [DATA_W-1:0]      rd1,
  output logic [DATA_W-1:0]      rd2,
  output logic                   outValid,
  input  logic                   outAck,
  input  logic                   issueEn,
  input  logic [3:0]             issueReg
);

  localparam logic [DATA_W-1:0] PC_OFF = DATA_W'(PC_OFFSET);

  logic [DATA_W-1:0] src_val_s [0:15];
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic [DATA_W-1:0] rd1_r;
  logic [DATA_W-1:0] rd2_r;
  logic              out_valid_r;
  logic              stall_s;
  logic              ready_s;
  logic              accept_s;

  // Unpack the register bus; slot 15 is the PC view (wrapping add).
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      src_val_s[i] = regFlat[i*DATA_W +: DATA_W];
    end
    src_val_s[15] = pcIn + PC_OFF;
  end

  // Operand select with writeback forwarding; r15 never forwards.
  always_comb begin
    rd1_s = src_val_s[ra1];
    rd2_s = src_val_s[ra2];
    if (writeDataEn && (regToWrite == ra1) && (ra1 != 4'd15)) begin
      rd1_s = writeData;
    end else begin
      rd1_s = src_val_s[ra1];
    end
    if (writeDataEn && (regToWrite == ra2) && (ra2 != 4'd15)) begin
      rd2_s = writeData;
    end else begin
      rd2_s = src_val_s[ra2];
    end
  end

`ifdef REG_READ_SCOREBOARD_EN
  logic [14:0] busy_r;
  logic [14:0] busy_nxt_s;

  // Busy-bit update: a reserve beats a writeback to the same register.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < 15; i++) begin
      if (issueEn && (issueReg == 4'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (writeDataEn && (regToWrite == 4'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Stall while a requested source is busy, unless its writeback lands now
  // (the forwarding path then supplies the value).
  always_comb begin
    stall_s = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (rdReq && busy_r[i] && ((ra1 == 4'(i)) || (ra2 == 4'(i))) &&
          !(writeDataEn && (regToWrite == 4'(i)))) begin
        stall_s = 1'b1;
      end else begin
        stall_s = stall_s;
      end
    end
  end

  // Busy-bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 15'd0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end
`else
  // Reserve inputs have no function without the scoreboard.
  logic unused_issue_s;
  assign unused_issue_s = ^{issueEn, issueReg};
  assign stall_s        = 1'b0;
`endif

  // Handshake: free or being drained this cycle, not stalled, not in reset.
  always_comb begin
    ready_s  = !rst && (!out_valid_r || outAck) && !stall_s;
    accept_s = rdReq && ready_s;
  end

  // Output register: load on acceptance, drop valid on a bare ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      rd1_r       <= {DATA_W{1'b0}};
      rd2_r       <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      rd1_r       <= rd1_s;
      rd2_r       <= rd2_s;
    end else if (out_valid_r && outAck) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign rdReady  = ready_s;
  assign rd1      = rd1_r;
  assign rd2      = rd2_r;
  assign outValid = out_valid_r;

endmodule

// File: doc/reg_read_unit.md
REG_READ_UNIT -- requirements
Module: reg_read_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register data width.
REQ-002 SHALL have parameter PC_OFFSET, default 8: value added to pcIn when r15 is read.
REQ-003 SHALL have these ports, with clock and reset first:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- regFlat  in  15*DATA_W  r0..r14 register outputs; r0 in bits [DATA_W-1:0].
- pcIn  in  DATA_W  current PC.
- writeDataEn  in  1  writeback strobe, as driven into the write decoder.
- regToWrite  in  4  writeback register index.
- writeData  in  DATA_W  writeback value.
- rdReq  in  1  read request valid.
- ra1, ra2  in  4 each  source register indices.
- rdReady  out  1  request accepted this cycle when high together with rdReq.
- rd1, rd2  out  DATA_W each  registered read data.
- outValid  out  1  rd1 and rd2 hold unconsumed data.
- outAck  in  1  consumer takes rd1 and rd2.
- issueEn  in  1  destination-reserve strobe (used only when the scoreboard is built in).
- issueReg  in  4  register index to reserve.

Function
REQ-004 A request SHALL be accepted when rdReq && rdReady.
REQ-005 rdReady SHALL be combinational: (!outValid || outAck) && !stall. stall SHALL be constant 0 when the scoreboard is compiled out.
REQ-006 On acceptance, rd1 and rd2 SHALL load on the next edge, giving 1-cycle latency, and outValid SHALL be set.
REQ-007 Without acceptance, outValid && outAck SHALL clear outValid. rd1 and rd2 SHALL hold their values whenever no request is accepted.
REQ-008 A source index of 0..14 SHALL select the matching slice of regFlat. Index 15 SHALL return pcIn+PC_OFFSET, truncated to DATA_W bits (the sum wraps).
REQ-009 Forwarding: if writeDataEn is high and regToWrite equals a source index 0..14 in the acceptance cycle, that source SHALL return writeData instead of regFlat.
REQ-010 A writeback to index 15 SHALL NOT forward; r15 always reads as pcIn+PC_OFFSET.
REQ-011 The ra1 == ra2 case SHALL return identical values on rd1 and rd2, including forwarded values.
REQ-012 Accepting a new request in the same cycle that outAck consumes the old data SHALL keep outValid=1 with the new data, giving back-to-back throughput of 1 per cycle.
REQ-013 rd1 and rd2 SHALL NOT change while outValid=1 && !outAck.

Reset
REQ-014 While rst is high, on the edge: outValid=0, rd1=0, rd2=0, and all busy bits cleared.
REQ-015 rdReady SHALL be 0 while rst is high.
REQ-016 Reset asserted while outValid=1 SHALL discard the pending data with no outAck required.
REQ-017 The cycle after rst deasserts, the block SHALL be able to accept a request.

Configuration
REQ-018 Macro REG_READ_SCOREBOARD_EN SHALL gate the scoreboard feature.
REQ-019 With the macro defined, the block SHALL keep 15 busy bits, one per r0..r14:
- issueEn with issueReg 0..14 sets the bit.
- writeDataEn with regToWrite 0..14 clears the bit.
- If set and clear target the same register in the same cycle, set wins.
- issueReg=15 and regToWrite=15 SHALL be ignored.
REQ-020 With the macro defined, stall SHALL be 1 when rdReq is high and either source is busy, unless a writeDataEn to that same register occurs this cycle. That writeback clears the stall and the value is forwarded per REQ-009.
REQ-021 Without the macro, no busy bits SHALL exist, issueEn and issueReg SHALL be ignored, and stall SHALL be 0.

Verification
REQ-022 Reset read: reset, then r3=0x11, pcIn=0x100, rdReq with ra1=3, ra2=15 → next cycle rd1=0x11, rd2=0x108, outValid=1.
REQ-023 Forwarding: r5=0xAA, writeDataEn=1, regToWrite=5, writeData=0x55, rdReq with ra1=ra2=5 → rd1=rd2=0x55. Repeat with regToWrite=15 → r15 still reads pcIn+8.
REQ-024 Backpressure and throughput:
- Hold outAck=0 with rdReq=1 → rdReady=0 and rd1 unchanged.
- Pulse outAck together with a new request → new data on the next cycle and outValid stays 1.
REQ-025 PC wrap: pcIn=0xFFFFFFFC, ra1=15 → rd1=0x00000004.
REQ-026 Scoreboard, macro defined:
- issueEn with issueReg=7, then rdReq with ra1=7 → rdReady=0 for the following cycles.
- writeDataEn=1, regToWrite=7, writeData=0x77 → accepted that cycle and rd1=0x77.
- Same sequence with the macro undefined → accepted immediately with regFlat's value of r7.
REQ-027 Reset mid-operation: outValid=1 with outAck=0, assert rst → outValid=0, rd1=rd2=0, busy bits cleared.
